// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA plot port: sprite drawers request solid
// rectangles, and every frame_tick schedules a full-screen clear ahead of them.
//
// state | meaning
// IDLE  | waiting; a pending clear wins over any sprite request
// CLEAR | painting BG_COLOUR over the whole screen, row-major
// DRAW  | scanning the granted rectangle, one pixel per cycle
// DONE  | one-cycle completion pulse, round-robin pointer advances
module vga_draw_arbiter #(
  parameter int NREQ = 4,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int SW = 5,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [CW-1:0] BG_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_tick,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*XW-1:0]   req_x,
  input  logic [NREQ*YW-1:0]   req_y,
  input  logic [NREQ*SW-1:0]   req_w,
  input  logic [NREQ*SW-1:0]   req_h,
  input  logic [NREQ*CW-1:0]   req_colour,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 plot,
  output logic [XW-1:0]        x_out,
  output logic [YW-1:0]        y_out,
  output logic [CW-1:0]        colour_out,
  output logic                 busy,
  output logic                 overrun
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam logic [XW:0]   SCR_W   = XW1'(SCREEN_W);
  localparam logic [YW:0]   SCR_H   = YW1'(SCREEN_H);
  localparam logic [XW-1:0] CLR_XL  = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] CLR_YL  = YW'(SCREEN_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DONE} state_t;

  state_t state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [XW-1:0]   x0_q, x0_d, cx_q, cx_d;
  logic [YW-1:0]   y0_q, y0_d, cy_q, cy_d;
  logic [SW-1:0]   w_q, w_d, h_q, h_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d;
  logic            plot_q, plot_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [XW-1:0]   x_out_q, x_out_d;
  logic [YW-1:0]   y_out_q, y_out_d;
  logic [CW-1:0]   colour_out_q, colour_out_d;

  logic [XW-1:0] rx [NREQ];
  logic [YW-1:0] ry [NREQ];
  logic [SW-1:0] rw [NREQ];
  logic [SW-1:0] rh [NREQ];
  logic [CW-1:0] rc [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rx[g] = req_x[g*XW +: XW];
    assign ry[g] = req_y[g*YW +: YW];
    assign rw[g] = req_w[g*SW +: SW];
    assign rh[g] = req_h[g*SW +: SW];
    assign rc[g] = req_colour[g*CW +: CW];
  end

  // First requester at or after the pointer; descending loop lets the nearest win.
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + IW1'(k);
      if (cand >= IW1'(NREQ)) cand = cand - IW1'(NREQ);
      if (req[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  logic          emit_draw, emit_clear;
  logic [XW:0]   px;
  logic [YW:0]   py;
  logic [XW-1:0] w_last;
  logic [YW-1:0] h_last;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    fill_d       = fill_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    grant_d      = grant_q;
    done_d       = '0;
    plot_d       = 1'b0;
    overrun_d    = 1'b0;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;
    emit_draw    = 1'b0;
    emit_clear   = 1'b0;
    px           = '0;
    py           = '0;
    w_last       = XW'(w_q - SW'(1));
    h_last       = YW'(h_q - SW'(1));

    case (state_q)
      S_IDLE: begin
        if (pend_q || frame_tick) begin
          state_d    = S_CLEAR;
          pend_d     = 1'b0;
          cx_d       = '0;
          cy_d       = '0;
          emit_clear = 1'b1;
        end else if (pick_vld) begin
          idx_d   = pick_idx;
          x0_d    = rx[pick_idx];
          y0_d    = ry[pick_idx];
          w_d     = rw[pick_idx];
          h_d     = rh[pick_idx];
          fill_d  = rc[pick_idx];
          cx_d    = '0;
          cy_d    = '0;
          grant_d = NREQ'(1) << pick_idx;
          if (rw[pick_idx] == '0 || rh[pick_idx] == '0) begin
            state_d = S_DONE;
            done_d  = NREQ'(1) << pick_idx;
          end else begin
            state_d   = S_DRAW;
            emit_draw = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (frame_tick) overrun_d = 1'b1;
        if (cx_q == CLR_XL && cy_q == CLR_YL) begin
          state_d = S_IDLE;
        end else begin
          if (cx_q == CLR_XL) begin
            cx_d = '0;
            cy_d = cy_q + YW'(1);
          end else begin
            cx_d = cx_q + XW'(1);
          end
          emit_clear = 1'b1;
        end
      end
      S_DRAW: begin
        if (frame_tick) pend_d = 1'b1;
        if (cx_q == w_last && cy_q == h_last) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end else begin
          if (cx_q == w_last) begin
            cx_d = '0;
            cy_d = cy_q + YW'(1);
          end else begin
            cx_d = cx_q + XW'(1);
          end
          emit_draw = 1'b1;
        end
      end
      S_DONE: begin
        if (frame_tick) pend_d = 1'b1;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Sums carry one extra bit so wrap-around past the screen edge is still clipped.
    if (emit_draw) begin
      px           = {1'b0, x0_d} + {1'b0, cx_d};
      py           = {1'b0, y0_d} + {1'b0, cy_d};
      x_out_d      = px[XW-1:0];
      y_out_d      = py[YW-1:0];
      colour_out_d = fill_d;
      plot_d       = (px < SCR_W) && (py < SCR_H);
    end else if (emit_clear) begin
      x_out_d      = cx_d;
      y_out_d      = cy_d;
      colour_out_d = BG_COLOUR;
      plot_d       = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      fill_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      fill_q       <= fill_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: random rectangles and request sets checked against
// a transaction-level model of round-robin order, clipping and clear timing.
module tb_vga_draw_arbiter;
  localparam int NREQ = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*XW-1:0] req_x = '0;
  logic [NREQ*YW-1:0] req_y = '0;
  logic [NREQ*SW-1:0] req_w = '0;
  logic [NREQ*SW-1:0] req_h = '0;
  logic [NREQ*CW-1:0] req_colour = '0;
  logic [NREQ-1:0] grant, done;
  logic plot, busy, overrun;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] colour_out;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;

  vga_draw_arbiter dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .req(req),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .req_colour(req_colour), .grant(grant), .done(done), .plot(plot),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_fields(input int i, input int x, input int y, input int w, input int h,
                            input int c);
    req_x[i*XW +: XW]      = XW'(x);
    req_y[i*YW +: YW]      = YW'(y);
    req_w[i*SW +: SW]      = SW'(w);
    req_h[i*SW +: SW]      = SW'(h);
    req_colour[i*CW +: CW] = CW'(c);
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int vis(input int x, input int y, input int w, input int h);
    int nx, ny;
    nx = (x >= 160) ? 0 : ((x + w > 160) ? 160 - x : w);
    ny = (y >= 120) ? 0 : ((y + h > 120) ? 120 - y : h);
    return nx * ny;
  endfunction

  // Single requester draw, checked pixel by pixel; optional frame_tick at pixel tick_at.
  task automatic draw_one(input int i, input int x, input int y, input int w, input int h,
                          input int c, input bit drop_early, input int tick_at);
    bit got;
    bit ep;
    int k;
    logic [3:0] oh;
    oh = 4'(1 << i);
    set_fields(i, x, y, w, h, c);
    req[i] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (grant != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("grant_wait", 32'(got), 32'd1);
    if (!got) begin
      req[i] = 1'b0;
      return;
    end
    chk("busy", 32'(busy), 32'd1);
    k = 0;
    for (int r = 0; r < h; r++) begin
      for (int cc = 0; cc < w; cc++) begin
        ep = (x + cc < 160) && (y + r < 120);
        chk("pixel", {grant, plot, x_out, y_out}, {oh, ep, 8'(x + cc), 7'(y + r)});
        if (ep) chk("colour", 32'(colour_out), 32'(c));
        if (k == 0) begin
          set_fields(i, $urandom, $urandom, $urandom, $urandom, $urandom);
          if (drop_early) req[i] = 1'b0;
        end
        frame_tick = (k == tick_at);
        k++;
        @(negedge clk);
      end
    end
    frame_tick = 1'b0;
    chk("done", {grant, done, plot}, {oh, oh, 1'b0});
    req[i] = 1'b0;
    ptr_m = (i + 1) % NREQ;
    @(negedge clk);
    chk("after_done", {grant, done, plot}, 32'd0);
  endtask

  // Hold a set of requests and follow ngr grants through the round-robin model.
  task automatic rr_round(input logic [3:0] mask, input int ngr, input int maxwh);
    int rxv[NREQ], ryv[NREQ], rwv[NREQ], rhv[NREQ];
    int e, cyc, plots;
    bit got;
    for (int i = 0; i < NREQ; i++) begin
      rxv[i] = $urandom_range(0, 170);
      ryv[i] = $urandom_range(0, 125);
      rwv[i] = $urandom_range(1, maxwh);
      rhv[i] = $urandom_range(1, maxwh);
      set_fields(i, rxv[i], ryv[i], rwv[i], rhv[i], $urandom_range(0, 7));
    end
    req = mask;
    for (int g = 0; g < ngr; g++) begin
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (grant != '0) begin
          got = 1'b1;
          break;
        end
      end
      chk("rr_wait", 32'(got), 32'd1);
      if (!got) begin
        req = '0;
        return;
      end
      e = rr_pick(mask, ptr_m);
      chk("rr_grant", 32'(grant), 32'(1 << e));
      cyc = 0;
      plots = 0;
      while (done == '0 && cyc < 2000) begin
        cyc++;
        plots += int'(plot);
        @(negedge clk);
      end
      chk("rr_len", 32'(cyc), 32'(rwv[e] * rhv[e]));
      chk("rr_done", 32'(done), 32'(1 << e));
      chk("rr_plots", 32'(plots), 32'(vis(rxv[e], ryv[e], rwv[e], rhv[e])));
      if (g == ngr - 1) req = '0;
      ptr_m = (e + 1) % NREQ;
    end
    @(negedge clk);
    chk("rr_idle", 32'(grant), 32'd0);
  endtask

  task automatic check_clear(input int tick_i);
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      chk("clear_px", {grant, busy, overrun, plot, x_out, y_out, colour_out},
          {4'b0, 1'b1, (i == tick_i + 1), 1'b1, 8'(i % 160), 7'(i / 160), 3'b000});
      frame_tick = (i == tick_i);
    end
    frame_tick = 1'b0;
    @(negedge clk);
    chk("clear_end", {busy, plot, overrun, grant}, 32'd0);
  endtask

  initial begin
    int i, x, y, w, h;
    bit got;
    req = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset_out", {grant, done, plot, busy, overrun, x_out, y_out, colour_out}, 32'd0);
    req = '0;
    resetn = 1'b1;
    ptr_m = 0;

    rr_round(4'b0011, 4, 1);
    draw_one(0, 10, 20, 3, 2, 5, 1'b0, -1);
    draw_one(3, 158, 119, 4, 2, 6, 1'b0, -1);
    draw_one(2, 30, 40, 0, 3, 7, 1'b0, -1);
    draw_one(1, 5, 6, 5, 0, 2, 1'b0, -1);

    repeat (25) begin
      i = $urandom_range(0, 3);
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
      w = $urandom_range(0, 9);
      h = $urandom_range(0, 9);
      draw_one(i, x, y, w, h, $urandom_range(0, 7), 1'($urandom_range(0, 1)), -1);
    end

    repeat (6) rr_round(4'($urandom_range(1, 15)), $urandom_range(3, 8), 3);

    draw_one(0, 50, 60, 4, 4, 3, 1'b0, 2);
    set_fields(1, 70, 80, 2, 2, 4);
    req[1] = 1'b1;
    check_clear(5000);
    draw_one(1, 70, 80, 2, 2, 4, 1'b0, -1);

    set_fields(0, 20, 20, 8, 8, 1);
    req[0] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (grant != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_grant", 32'(got), 32'd1);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk("rst_mid", {grant, plot, busy, done}, 32'd0);
    req = '0;
    ptr_m = 0;
    @(negedge clk);
    resetn = 1'b1;
    rr_round(4'b0101, 2, 2);
    draw_one(2, 100, 100, 2, 3, 6, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
